// File: rtl/ahb_manager_arbiter.sv
// rtl/ahb_manager_arbiter.sv - IFU/LSU AHB manager arbiter with address-phase capture and burst hold
`timescale 1ns/1ps
module ahb_manager_arbiter #(
    parameter int PA_BITS = 34,
    parameter int AHBW    = 64
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [PA_BITS-1:0]   IFUHADDR,
    input  logic [1:0]           IFUHTRANS,
    input  logic [2:0]           IFUHSIZE,
    input  logic [2:0]           IFUHBURST,
    output logic                 IFUHREADY,
    input  logic [PA_BITS-1:0]   LSUHADDR,
    input  logic [1:0]           LSUHTRANS,
    input  logic                 LSUHWRITE,
    input  logic [2:0]           LSUHSIZE,
    input  logic [2:0]           LSUHBURST,
    input  logic [AHBW-1:0]      LSUHWDATA,
    input  logic [AHBW/8-1:0]    LSUHWSTRB,
    output logic                 LSUHREADY,
    input  logic                 HREADY,
    output logic [PA_BITS-1:0]   HADDR,
    output logic [1:0]           HTRANS,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [2:0]           HBURST,
    output logic [AHBW-1:0]      HWDATA,
    output logic [AHBW/8-1:0]    HWSTRB
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [2:0] BURST_INCR = 3'b001;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_IFU = 2'd1, ST_LSU = 2'd2} state_e;
    typedef enum logic [1:0] {DO_NONE = 2'd0, DO_IFU = 2'd1, DO_LSU = 2'd2} data_own_e;

    state_e              state_q, state_d;
    data_own_e           down_q, down_d;
    logic                dwrite_q, dwrite_d;
    logic                last_lsu_q, last_lsu_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                incr_q, incr_d;

    logic                pend_ifu_q, pend_ifu_d;
    logic [PA_BITS-1:0]  ifu_addr_q, ifu_addr_d;
    logic [2:0]          ifu_size_q, ifu_size_d;
    logic [2:0]          ifu_burst_q, ifu_burst_d;

    logic                pend_lsu_q, pend_lsu_d;
    logic [PA_BITS-1:0]  lsu_addr_q, lsu_addr_d;
    logic                lsu_write_q, lsu_write_d;
    logic [2:0]          lsu_size_q, lsu_size_d;
    logic [2:0]          lsu_burst_q, lsu_burst_d;

    logic                req_ifu, req_lsu;
    logic                own_ifu, own_lsu;
    logic [4:0]          first_len;

    function automatic logic [4:0] burst_len(input logic [2:0] b);
        case (b)
            3'b010, 3'b011: burst_len = 5'd4;
            3'b100, 3'b101: burst_len = 5'd8;
            3'b110, 3'b111: burst_len = 5'd16;
            default:        burst_len = 5'd1;
        endcase
    endfunction

    // Address-phase owner: registered state, or a same-cycle grant when idle.
    always_comb begin
        req_ifu = ~HRESET & (pend_ifu_q | (IFUHTRANS == TR_NONSEQ));
        req_lsu = ~HRESET & (pend_lsu_q | (LSUHTRANS == TR_NONSEQ));
        own_ifu = 1'b0;
        own_lsu = 1'b0;
        case (state_q)
            ST_IFU: own_ifu = 1'b1;
            ST_LSU: own_lsu = 1'b1;
            default: begin
                if (req_ifu && req_lsu) begin
                    own_ifu = last_lsu_q;
                    own_lsu = ~last_lsu_q;
                end else begin
                    own_ifu = req_ifu;
                    own_lsu = req_lsu;
                end
            end
        endcase
    end

    always_comb begin
        HADDR  = '0;
        HTRANS = TR_IDLE;
        HWRITE = 1'b0;
        HSIZE  = 3'b000;
        HBURST = 3'b000;
        if (own_ifu) begin
            if (pend_ifu_q) begin
                HADDR  = ifu_addr_q;
                HTRANS = TR_NONSEQ;
                HSIZE  = ifu_size_q;
                HBURST = ifu_burst_q;
            end else begin
                HADDR  = IFUHADDR;
                HTRANS = IFUHTRANS;
                HSIZE  = IFUHSIZE;
                HBURST = IFUHBURST;
            end
        end else if (own_lsu) begin
            if (pend_lsu_q) begin
                HADDR  = lsu_addr_q;
                HTRANS = TR_NONSEQ;
                HWRITE = lsu_write_q;
                HSIZE  = lsu_size_q;
                HBURST = lsu_burst_q;
            end else begin
                HADDR  = LSUHADDR;
                HTRANS = LSUHTRANS;
                HWRITE = LSUHWRITE;
                HSIZE  = LSUHSIZE;
                HBURST = LSUHBURST;
            end
        end
        if ((down_q == DO_LSU) && dwrite_q) begin
            HWDATA = LSUHWDATA;
            HWSTRB = LSUHWSTRB;
        end else begin
            HWDATA = '0;
            HWSTRB = '0;
        end
        IFUHREADY = HREADY & ~pend_ifu_q;
        LSUHREADY = HREADY & ~pend_lsu_q;
    end

    always_comb begin
        state_d     = state_q;
        down_d      = down_q;
        dwrite_d    = dwrite_q;
        last_lsu_d  = last_lsu_q;
        cnt_d       = cnt_q;
        incr_d      = incr_q;
        pend_ifu_d  = pend_ifu_q;
        ifu_addr_d  = ifu_addr_q;
        ifu_size_d  = ifu_size_q;
        ifu_burst_d = ifu_burst_q;
        pend_lsu_d  = pend_lsu_q;
        lsu_addr_d  = lsu_addr_q;
        lsu_write_d = lsu_write_q;
        lsu_size_d  = lsu_size_q;
        lsu_burst_d = lsu_burst_q;
        first_len   = burst_len(HBURST);

        if (HREADY) begin
            // A non-owner sees its NONSEQ accepted here, so it must be held.
            if (!own_ifu && !pend_ifu_q && (IFUHTRANS == TR_NONSEQ)) begin
                pend_ifu_d  = 1'b1;
                ifu_addr_d  = IFUHADDR;
                ifu_size_d  = IFUHSIZE;
                ifu_burst_d = IFUHBURST;
            end else if (own_ifu && pend_ifu_q) begin
                pend_ifu_d = 1'b0;
            end
            if (!own_lsu && !pend_lsu_q && (LSUHTRANS == TR_NONSEQ)) begin
                pend_lsu_d  = 1'b1;
                lsu_addr_d  = LSUHADDR;
                lsu_write_d = LSUHWRITE;
                lsu_size_d  = LSUHSIZE;
                lsu_burst_d = LSUHBURST;
            end else if (own_lsu && pend_lsu_q) begin
                pend_lsu_d = 1'b0;
            end

            if ((state_q == ST_IDLE) && (own_ifu || own_lsu)) begin
                last_lsu_d = own_lsu;
            end

            if (HTRANS == TR_IDLE) begin
                down_d   = DO_NONE;
                dwrite_d = 1'b0;
            end else begin
                down_d   = own_lsu ? DO_LSU : DO_IFU;
                dwrite_d = HWRITE;
            end

            if (!(own_ifu || own_lsu) || (HTRANS == TR_IDLE)) begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
                incr_d  = 1'b0;
            end else if (HTRANS == TR_BUSY) begin
                state_d = state_q;
            end else if (state_q == ST_IDLE) begin
                if (HBURST == BURST_INCR) begin
                    incr_d  = 1'b1;
                    cnt_d   = 5'd0;
                    state_d = own_lsu ? ST_LSU : ST_IFU;
                end else begin
                    incr_d  = 1'b0;
                    cnt_d   = first_len - 5'd1;
                    state_d = (first_len == 5'd1) ? ST_IDLE : (own_lsu ? ST_LSU : ST_IFU);
                end
            end else if (!incr_q) begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            down_q      <= DO_NONE;
            dwrite_q    <= 1'b0;
            last_lsu_q  <= 1'b0;
            cnt_q       <= 5'd0;
            incr_q      <= 1'b0;
            pend_ifu_q  <= 1'b0;
            ifu_addr_q  <= '0;
            ifu_size_q  <= 3'b000;
            ifu_burst_q <= 3'b000;
            pend_lsu_q  <= 1'b0;
            lsu_addr_q  <= '0;
            lsu_write_q <= 1'b0;
            lsu_size_q  <= 3'b000;
            lsu_burst_q <= 3'b000;
        end else begin
            state_q     <= state_d;
            down_q      <= down_d;
            dwrite_q    <= dwrite_d;
            last_lsu_q  <= last_lsu_d;
            cnt_q       <= cnt_d;
            incr_q      <= incr_d;
            pend_ifu_q  <= pend_ifu_d;
            ifu_addr_q  <= ifu_addr_d;
            ifu_size_q  <= ifu_size_d;
            ifu_burst_q <= ifu_burst_d;
            pend_lsu_q  <= pend_lsu_d;
            lsu_addr_q  <= lsu_addr_d;
            lsu_write_q <= lsu_write_d;
            lsu_size_q  <= lsu_size_d;
            lsu_burst_q <= lsu_burst_d;
        end
    end

endmodule

// File: tb/tb_ahb_manager_arbiter.sv
// tb/tb_ahb_manager_arbiter.sv - vector-driven self-checking bench for ahb_manager_arbiter
`timescale 1ns/1ps
module tb_ahb_manager_arbiter;

    localparam int PA = 34;
    localparam int DW = 64;
    localparam logic [1:0] TI = 2'b00;
    localparam logic [1:0] TN = 2'b10;
    localparam logic [1:0] TS = 2'b11;

    logic            HCLK = 1'b0;
    logic            HRESET = 1'b1;
    logic [PA-1:0]   IFUHADDR = '0;
    logic [1:0]      IFUHTRANS = TI;
    logic [2:0]      IFUHSIZE = 3'd3;
    logic [2:0]      IFUHBURST = 3'd0;
    logic            IFUHREADY;
    logic [PA-1:0]   LSUHADDR = '0;
    logic [1:0]      LSUHTRANS = TI;
    logic            LSUHWRITE = 1'b0;
    logic [2:0]      LSUHSIZE = 3'd2;
    logic [2:0]      LSUHBURST = 3'd0;
    logic [DW-1:0]   LSUHWDATA = '0;
    logic [DW/8-1:0] LSUHWSTRB = 8'h0F;
    logic            LSUHREADY;
    logic            HREADY = 1'b1;
    logic [PA-1:0]   HADDR;
    logic [1:0]      HTRANS;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [DW-1:0]   HWDATA;
    logic [DW/8-1:0] HWSTRB;

    always #5 HCLK = ~HCLK;

    ahb_manager_arbiter #(.PA_BITS(PA), .AHBW(DW)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .IFUHADDR(IFUHADDR), .IFUHTRANS(IFUHTRANS), .IFUHSIZE(IFUHSIZE), .IFUHBURST(IFUHBURST), .IFUHREADY(IFUHREADY),
        .LSUHADDR(LSUHADDR), .LSUHTRANS(LSUHTRANS), .LSUHWRITE(LSUHWRITE), .LSUHSIZE(LSUHSIZE), .LSUHBURST(LSUHBURST),
        .LSUHWDATA(LSUHWDATA), .LSUHWSTRB(LSUHWSTRB), .LSUHREADY(LSUHREADY),
        .HREADY(HREADY), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HWSTRB(HWSTRB)
    );

    typedef struct {
        logic rst, hr;
        logic [1:0] it; logic [PA-1:0] ia; logic [2:0] ib;
        logic [1:0] lt; logic [PA-1:0] la; logic lw; logic [2:0] lb; logic [DW-1:0] ld;
        logic [1:0] e_tr; logic [PA-1:0] e_a; logic e_w; logic [2:0] e_b; logic [2:0] e_sz; logic [DW-1:0] e_d;
        logic e_ir, e_lr;
    } vec_t;

    vec_t vecs[$];
    int n_tests = 0;
    int n_fail = 0;

    function automatic vec_t mk(input logic rst, input logic hr,
                                input logic [1:0] it, input logic [PA-1:0] ia, input logic [2:0] ib,
                                input logic [1:0] lt, input logic [PA-1:0] la, input logic lw, input logic [2:0] lb, input logic [DW-1:0] ld,
                                input logic [1:0] e_tr, input logic [PA-1:0] e_a, input logic e_w, input logic [2:0] e_b, input logic [2:0] e_sz, input logic [DW-1:0] e_d,
                                input logic e_ir, input logic e_lr);
        vec_t v;
        v.rst = rst; v.hr = hr;
        v.it = it; v.ia = ia; v.ib = ib;
        v.lt = lt; v.la = la; v.lw = lw; v.lb = lb; v.ld = ld;
        v.e_tr = e_tr; v.e_a = e_a; v.e_w = e_w; v.e_b = e_b; v.e_sz = e_sz; v.e_d = e_d;
        v.e_ir = e_ir; v.e_lr = e_lr;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        HRESET    = v.rst;
        HREADY    = v.hr;
        IFUHTRANS = v.it; IFUHADDR = v.ia; IFUHBURST = v.ib;
        LSUHTRANS = v.lt; LSUHADDR = v.la; LSUHWRITE = v.lw; LSUHBURST = v.lb; LSUHWDATA = v.ld;
    endtask

    task automatic check_outs(input vec_t v, input string tag);
        check({tag, ".htrans"}, 64'(HTRANS), 64'(v.e_tr));
        check({tag, ".haddr"}, 64'(HADDR), 64'(v.e_a));
        check({tag, ".hwrite"}, 64'(HWRITE), 64'(v.e_w));
        check({tag, ".hburst"}, 64'(HBURST), 64'(v.e_b));
        check({tag, ".hsize"}, 64'(HSIZE), 64'(v.e_sz));
        check({tag, ".hwdata"}, HWDATA, v.e_d);
        check({tag, ".hwstrb"}, 64'(HWSTRB), (v.e_d != 0) ? 64'h0F : 64'h00);
        check({tag, ".ifuhready"}, 64'(IFUHREADY), 64'(v.e_ir));
        check({tag, ".lsuhready"}, 64'(LSUHREADY), 64'(v.e_lr));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge HCLK);
        drive(v);
        #2;
        check_outs(v, tag);
    endtask

    initial begin
        // reset, contention, round-robin
        vecs.push_back(mk(1,1, TN,'h2000,3, TN,'h1000,1,0,0,      TI,0,0,0,0,0,            1,1));
        vecs.push_back(mk(1,0, TI,0,0,      TI,0,0,0,0,           TI,0,0,0,0,0,            0,0));
        vecs.push_back(mk(0,1, TN,'h2000,3, TN,'h1000,1,0,0,      TN,'h1000,1,0,2,0,       1,1));
        vecs.push_back(mk(0,1, TS,'h2008,3, TI,0,0,0,'hDEAD,      TN,'h2000,0,3,3,'hDEAD,  0,1));
        vecs.push_back(mk(0,1, TS,'h2008,3, TI,0,0,0,0,           TS,'h2008,0,3,3,0,       1,1));
        vecs.push_back(mk(0,1, TS,'h2010,3, TI,0,0,0,0,           TS,'h2010,0,3,3,0,       1,1));
        vecs.push_back(mk(0,1, TS,'h2018,3, TI,0,0,0,0,           TS,'h2018,0,3,3,0,       1,1));
        vecs.push_back(mk(0,1, TN,'h3000,0, TN,'h4000,0,0,0,      TN,'h4000,0,0,2,0,       1,1));
        vecs.push_back(mk(0,1, TI,0,0,      TN,'h4100,0,0,0,      TN,'h3000,0,0,3,0,       0,1));
        vecs.push_back(mk(0,1, TN,'h3100,0, TI,0,0,0,0,           TN,'h4100,0,0,2,0,       1,0));
        vecs.push_back(mk(0,1, TI,0,0,      TI,0,0,0,0,           TN,'h3100,0,0,3,0,       0,1));
        vecs.push_back(mk(0,1, TI,0,0,      TI,0,0,0,0,           TI,0,0,0,0,0,            1,1));
        // IFU INCR8, then LSU INCR with IFU captured mid-burst
        for (int k = 0; k < 8; k++) begin
            logic [PA-1:0] a;
            logic [1:0] t;
            a = 34'h0_8000_0000 + 34'(8 * k);
            t = (k == 0) ? TN : TS;
            vecs.push_back(mk(0,1, t,a,5, TI,0,0,0,0, t,a,0,5,3,0, 1,1));
        end
        vecs.push_back(mk(0,1, TI,0,0,      TN,'h5000,1,1,0,      TN,'h5000,1,1,2,0,       1,1));
        vecs.push_back(mk(0,1, TN,'h6000,0, TS,'h5004,1,1,'hA1,   TS,'h5004,1,1,2,'hA1,    1,1));
        vecs.push_back(mk(0,1, TI,0,0,      TS,'h5008,1,1,'hA2,   TS,'h5008,1,1,2,'hA2,    0,1));
        vecs.push_back(mk(0,1, TI,0,0,      TI,0,0,0,'hA3,        TI,0,0,0,2,'hA3,         0,1));
        vecs.push_back(mk(0,1, TI,0,0,      TI,0,0,0,0,           TN,'h6000,0,0,3,0,       0,1));
        vecs.push_back(mk(0,1, TI,0,0,      TI,0,0,0,0,           TI,0,0,0,0,0,            1,1));

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // wait states in the middle of an IFU INCR4 with an LSU request arriving
        run_vec(mk(0,1, TN,'h7000,3, TI,0,0,0,0, TN,'h7000,0,3,3,0, 1,1), "wait0");
        run_vec(mk(0,1, TS,'h7008,3, TI,0,0,0,0, TS,'h7008,0,3,3,0, 1,1), "wait1");
        for (int w = 0; w < 3; w++) begin
            run_vec(mk(0,0, TS,'h7010,3, TN,'h9000,0,0,0, TS,'h7010,0,3,3,0, 0,0), $sformatf("wait_hr0_%0d", w));
        end
        run_vec(mk(0,1, TS,'h7010,3, TN,'h9000,0,0,0, TS,'h7010,0,3,3,0, 1,1), "wait5");
        run_vec(mk(0,1, TS,'h7018,3, TI,0,0,0,0,      TS,'h7018,0,3,3,0, 1,0), "wait6");
        run_vec(mk(0,1, TI,0,0,      TI,0,0,0,0,      TN,'h9000,0,0,2,0, 1,0), "wait7");
        run_vec(mk(0,1, TI,0,0,      TI,0,0,0,0,      TI,0,0,0,0,0,      1,1), "wait8");

        // asynchronous reset during beat 2 of an LSU INCR4 write
        run_vec(mk(0,1, TI,0,0, TN,'hA000,1,3,0,    TN,'hA000,1,3,2,0,    1,1), "rst0");
        run_vec(mk(0,1, TI,0,0, TS,'hA008,1,3,'h11, TS,'hA008,1,3,2,'h11, 1,1), "rst1");
        HRESET = 1'b1;
        #1;
        check("rst_async.htrans", 64'(HTRANS), 64'h0);
        check("rst_async.haddr", 64'(HADDR), 64'h0);
        check("rst_async.hwdata", HWDATA, 64'h0);
        check("rst_async.hwstrb", 64'(HWSTRB), 64'h0);
        check("rst_async.ifuhready_hi", 64'(IFUHREADY), 64'h1);
        check("rst_async.lsuhready_hi", 64'(LSUHREADY), 64'h1);
        HREADY = 1'b0;
        #1;
        check("rst_async.ifuhready_lo", 64'(IFUHREADY), 64'h0);
        check("rst_async.lsuhready_lo", 64'(LSUHREADY), 64'h0);
        run_vec(mk(0,1, TN,'hB000,0, TN,'hC000,0,0,0, TN,'hC000,0,0,2,0, 1,1), "rst2");
        run_vec(mk(0,1, TI,0,0,      TI,0,0,0,0,      TN,'hB000,0,0,3,0, 0,1), "rst3");
        run_vec(mk(0,1, TI,0,0,      TI,0,0,0,0,      TI,0,0,0,0,0,      1,1), "rst4");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
